jt12_status: RTL

JT12_STATUS -- requirements
Module: jt12_status

---
 rtl/jt12_status_pkg.sv | 16 +
 rtl/jt12_busy_cnt.sv | 31 +++
 rtl/jt12_status.sv | 101 ++++++++++
 3 files changed

// File: rtl/jt12_status_pkg.sv
// Shared constants for the JT12 status/read-back block: CPU port decode and
// busy-counter sizing.
package jt12_status_pkg;

   localparam logic [1:0] STAT  = 2'b00;
   localparam logic [1:0] SSG   = 2'b01;
   localparam logic [1:0] ADPCM = 2'b1?;   // bit 0 is a don't-care (casez item)

   localparam int DEF_BUSY_CYCLES = 32;

   // Bits needed to hold the value `cycles` itself.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/jt12_busy_cnt.sv
// Write-busy timer: a data write loads the full count, cen ticks drain it to 0.
module jt12_busy_cnt
   import jt12_status_pkg::*;
#(
   parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic cen,
   input  logic load,
   output logic busy
);

   localparam int W = cnt_width(BUSY_CYCLES);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its inputs from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= W'(BUSY_CYCLES);
      else if (cen && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/jt12_status.sv
// CPU read-back for the JT12: status byte, optional SSG data and sticky
// ADPCM end flags with mask/clear, plus the registered IRQ line.
module jt12_status
   import jt12_status_pkg::*;
#(
   parameter int USE_SSG     = 0,
   parameter int USE_ADPCM   = 0,
   parameter int ADPCMA_CH   = 6,
   parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cen,
   input  logic                 wr_n,
   input  logic [1:0]           addr,
   input  logic                 flag_A,
   input  logic                 flag_B,
   input  logic [1:0]           tirq_en,
   input  logic [ADPCMA_CH-1:0] adpcma_end,
   input  logic                 adpcmb_end,
   input  logic                 flagctl_we,
   input  logic [7:0]           flagctl,
   input  logic [7:0]           psg_dout,
   output logic [7:0]           dout,
   output logic                 busy,
   output logic                 irq_n
);

   logic                 wr_data;
   logic [ADPCMA_CH-1:0] aflags;
   logic                 bflag;
   logic [7:0]           status;
   logic [7:0]           adpcm_byte;
   logic                 unused_inputs;

   assign wr_data = ~wr_n & addr[0];

   jt12_busy_cnt #(
      .BUSY_CYCLES(BUSY_CYCLES)
   ) u_busy (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .load(wr_data),
      .busy(busy)
   );

   generate
      if (USE_ADPCM != 0) begin : g_adpcm
         logic [ADPCMA_CH-1:0] amask, amask_nx;
         logic                 bmask, bmask_nx;

         // NOTE: every variable gets a value on every path of always_comb,
         // otherwise synthesis infers a latch.
         always_comb begin
            amask_nx = flagctl_we ? flagctl[ADPCMA_CH-1:0] : amask;
            bmask_nx = flagctl_we ? flagctl[7]             : bmask;
         end

         // Clearing with the next mask value makes a same-clk mask-set beat
         // an arriving end pulse.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               amask  <= '0;
               bmask  <= 1'b0;
               aflags <= '0;
               bflag  <= 1'b0;
            end else begin
               amask  <= amask_nx;
               bmask  <= bmask_nx;
               aflags <= (aflags | adpcma_end) & ~amask_nx;
               bflag  <= (bflag | adpcmb_end) & ~bmask_nx;
            end
         end
      end else begin : g_no_adpcm
         assign aflags = '0;
         assign bflag  = 1'b0;
      end
   endgenerate

   assign status     = {busy, 5'd0, flag_B, flag_A};
   assign adpcm_byte = {bflag, 1'b0, 6'(aflags)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout  <= 8'h00;
         irq_n <= 1'b1;
      end else begin
         casez (addr)
            SSG:     dout <= (USE_SSG   != 0) ? psg_dout   : status;
            ADPCM:   dout <= (USE_ADPCM != 0) ? adpcm_byte : status;
            default: dout <= status;
         endcase
         irq_n <= ~((flag_A & tirq_en[0]) | (flag_B & tirq_en[1]) | (|aflags) | bflag);
      end
   end

   // Inputs that some parameter settings leave unread.
   assign unused_inputs = ^{psg_dout, flagctl, flagctl_we, adpcma_end, adpcmb_end};

endmodule
